// File: rtl/shift_seq_unit.sv
// Iterative one-bit-per-cycle shifter (SLL/SRL/SRA) for the multicycle MIPS datapath.
// Optional rotate-right op (code 101) is enabled by defining SHIFT_SEQ_ROR_EN.
module shift_seq_unit #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       sh_op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             op_err
);

  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;
`ifdef SHIFT_SEQ_ROR_EN
  localparam logic [2:0] OP_ROR = 3'b101;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_data_out;
  logic             r_op_err;

  logic             w_op_ok;
  logic [WIDTH-1:0] w_shift;

  function automatic logic f_op_valid(input logic [2:0] op);
    logic v;
    case (op)
      OP_SLL:  v = 1'b1;
      OP_SRL:  v = 1'b1;
      OP_SRA:  v = 1'b1;
`ifdef SHIFT_SEQ_ROR_EN
      OP_ROR:  v = 1'b1;
`endif
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // One-position step of the latched operation; unknown ops leave the value untouched.
  function automatic logic [WIDTH-1:0] f_step(input logic [2:0] op, input logic [WIDTH-1:0] val);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = {val[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, val[WIDTH-1:1]};
      OP_SRA:  r = {val[WIDTH-1], val[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROR_EN
      OP_ROR:  r = {val[0], val[WIDTH-1:1]};
`endif
      default: r = val;
    endcase
    return r;
  endfunction

  assign w_op_ok = f_op_valid(sh_op);
  assign w_shift = f_step(r_op, r_work);

  // Control FSM, working datapath and registered handshake outputs.
  // data_out/op_err are loaded on the edge that enters FINISH so they are valid with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_work     <= {WIDTH{1'b0}};
      r_cnt      <= {AMT_W{1'b0}};
      r_op       <= 3'b000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= {WIDTH{1'b0}};
      r_op_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_work <= data_in;
            r_cnt  <= shamt;
            r_op   <= sh_op;
            r_busy <= 1'b1;
            if (!w_op_ok) begin
              r_op_err   <= 1'b1;
              r_data_out <= {WIDTH{1'b0}};
              r_done     <= 1'b1;
              r_state    <= S_FINISH;
            end else if (shamt == {AMT_W{1'b0}}) begin
              r_op_err   <= 1'b0;
              r_data_out <= data_in;
              r_done     <= 1'b1;
              r_state    <= S_FINISH;
            end else begin
              r_op_err <= 1'b0;
              r_state  <= S_SHIFT;
            end
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_work <= w_shift;
          r_cnt  <= r_cnt - {{(AMT_W-1){1'b0}}, 1'b1};
          r_busy <= 1'b1;
          if (r_cnt == {{(AMT_W-1){1'b0}}, 1'b1}) begin
            r_data_out <= w_shift;
            r_done     <= 1'b1;
            r_state    <= S_FINISH;
          end else begin
            r_done  <= 1'b0;
            r_state <= S_SHIFT;
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_data_out;
  assign op_err   = r_op_err;

endmodule
